pitch_shift_rebin: RTL and testbench
====================================

// Module: pitch_shift_rebin
// PURPOSE
//  Sink for the PitchShift bin-remap stream: takes (output_index, data_out) pairs, sums all
//  source bins landing on the same destination bin, then replays the rebuilt spectrum in bin
//  order 0..NUM_BINS-1 toward the IFFT. Ping-pong banks: one fills while the other drains.
// PARAMETERS
//  NUM_BINS  2048  bins per frame (power of two)
//  IDX_W     11    bin index width, log2(NUM_BINS)
//  DATA_W    44    complex bin word: [43:22] real, [21:0] imag, each two's complement
// PORTS
//  clk        in   1       clock
//  rst_n      in   1       async active-low reset
//  in_valid   in   1       in_index/in_data valid
//  in_ready   out  1       block accepts pair this cycle
//  in_index   in   IDX_W   destination bin (PitchShift output_index)
//  in_data    in   DATA_W  bin value (PitchShift data_out)
//  in_last    in   1       final pair of frame; qualified by in_valid&in_ready
//  out_valid  out  1       out_data valid
//  out_ready  in   1       IFFT accepts
//  out_data   out  DATA_W  accumulated bin value
//  out_index  out  IDX_W   bin number of out_data
//  out_last   out  1       high with bin NUM_BINS-1
// BEHAVIOUR
//  - Reset: in_ready=0, out_valid=0, out_data=0, out_index=0, out_last=0; fill bank=0.
//  - Write FSM: INIT -> FILL -> (DRAIN_PIPE) -> SWAP_WAIT -> FILL.
//    INIT: zero both banks, 1 addr/cycle, NUM_BINS cycles, in_ready=0; then FILL.
//    FILL: in_ready=1; accepted pair does RMW: bank[idx] += in_data (real/imag lanes
//    independent). 2-stage pipe (read, add+write); back-to-back or 1-apart same index
//    forwards pending sum, no lost update. Any order, any count of pairs per frame.
//    On accepted in_last: in_ready=0, drain pipe (2 cycles), go SWAP_WAIT.
//    SWAP_WAIT: when read side idle, hand bank over, toggle fill bank, return to FILL
//    (same cycle swap allowed). Bins never written read back as 0.
//  - Read FSM: R_IDLE -> R_STREAM -> R_IDLE.
//    R_STREAM: out_valid first high 2 cycles after swap; bins emitted ascending, exactly
//    NUM_BINS beats. Handshake = out_valid&out_ready; out_* held stable while stalled.
//    Each emitted bin is zeroed in its bank on handshake (read-and-clear), so the bank
//    is clean for reuse with no extra sweep. After bin NUM_BINS-1 (out_last) -> R_IDLE.
//  - Throughput: 1 pair/cycle in, 1 bin/cycle out with out_ready held high.
//  - in_last with no prior pairs in frame: valid; emits an all-zero... except that pair.
//  - in_valid while in_ready=0: ignored, no state change.
//  - rst_n low mid-frame: all state aborted, partial frames lost, INIT re-runs.
// CONFIGURATION
//  ACCUM_SAT_EN defined: each 22-bit lane sum saturates to +2^21-1 / -2^21.
//  Undefined: lane sums wrap modulo 2^22. Read/handshake behaviour identical either way.
// TESTING
//  - Reset, hold NUM_BINS+5 cycles: in_ready rises exactly after NUM_BINS INIT cycles; outputs 0.
//  - Identity frame: idx i, data {i,−i} for i=0..2047, in_last on 2047 -> out bin i = {i,−i}, out_last at 2047.
//  - Collision: idx 5 data 0x7FFF three back-to-back + in_last -> bin5 = 3*0x7FFF real, others 0.
//  - Sat: idx 0 real 0x1FFFFF twice -> ACCUM_SAT_EN 0x1FFFFF; without, 0x3FFFFE (wrap, -2).
//  - Backpressure: out_ready toggled 1/0 per cycle while 2nd frame fills -> all 2048 bins
//    in order, stable when stalled; 3rd frame in_last held off (in_ready=0) until drain ends.
//  - Reset asserted mid R_STREAM at bin 700 -> outputs 0 next cycle, INIT, next frame clean (no stale bins).

Source files
------------

// File: rtl/pitch_shift_rebin.sv
// Purpose: accumulate (index, value) bin pairs into a ping-pong spectrum bank and replay it in bin order.
// Latency: 2-cycle read-modify-write on input; first out_valid 2 cycles after a bank swap, then 1 bin/cycle.
// Backpressure: in_ready low during INIT, pipe drain and swap wait; out_* hold while out_ready is low.
// Optional build macro ACCUM_SAT_EN: lane sums saturate instead of wrapping.
module pitch_shift_rebin #(
  parameter int NUM_BINS = 2048,
  parameter int IDX_W    = 11,
  parameter int DATA_W   = 44
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [IDX_W-1:0]  in_index,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [IDX_W-1:0]  out_index,
  output logic              out_last
);

  localparam int LANE_W = DATA_W / 2;

  typedef enum logic [1:0] {W_INIT, W_FILL, W_DRAIN, W_SWAP} w_state_t;
  typedef enum logic {R_IDLE, R_STREAM} r_state_t;

  w_state_t w_state, w_next;
  r_state_t r_state, r_next;

  logic [IDX_W-1:0]  init_addr;
  logic              drain_cnt;
  logic              fill_bank;

  logic [DATA_W-1:0] bank0 [NUM_BINS];
  logic [DATA_W-1:0] bank1 [NUM_BINS];

  // per-bank write port, shared by init sweep, accumulate and read-and-clear
  logic              b0_we, b1_we;
  logic [IDX_W-1:0]  b0_addr, b1_addr;
  logic [DATA_W-1:0] b0_dat, b1_dat;

  // accumulate pipeline: s1 = read returned, s2 = sum just written (forwarding source)
  logic              s1_vld, s2_vld;
  logic [IDX_W-1:0]  s1_idx, s2_idx;
  logic [DATA_W-1:0] s1_dat, s1_rd, s2_sum;
  logic [DATA_W-1:0] s1_base, s1_sum;

  logic [IDX_W:0]    rd_addr;
  logic              accept, out_hs, read_free, swap_go, rd_load;

  // one two's-complement lane add; wraps, or clamps when ACCUM_SAT_EN is defined
  function automatic logic [LANE_W-1:0] lane_add(input logic [LANE_W-1:0] a,
                                                  input logic [LANE_W-1:0] b);
    logic [LANE_W:0]   s;
    logic [LANE_W-1:0] r;
    s = {a[LANE_W-1], a} + {b[LANE_W-1], b};
    r = s[LANE_W-1:0];
`ifdef ACCUM_SAT_EN
    if (s[LANE_W] != s[LANE_W-1])
      r = s[LANE_W] ? {1'b1, {(LANE_W-1){1'b0}}} : {1'b0, {(LANE_W-1){1'b1}}};
`endif
    return r;
  endfunction

  assign accept    = in_valid & in_ready;
  assign out_hs    = out_valid & out_ready;
  // the drain side is free when idle or handing off its final bin this cycle
  assign read_free = (r_state == R_IDLE) | (out_hs & out_last);
  assign swap_go   = (w_state == W_SWAP) & read_free;
  assign rd_load   = (r_state == R_STREAM) & ~rd_addr[IDX_W] & (~out_valid | out_ready);

  // write-side state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) w_state <= W_INIT;
    else        w_state <= w_next;
  end

  // write-side next state and input handshake
  always_comb begin
    w_next   = w_state;
    in_ready = 1'b0;
    case (w_state)
      W_INIT:  if (init_addr == IDX_W'(NUM_BINS - 1)) w_next = W_FILL;
      W_FILL: begin
        in_ready = 1'b1;
        if (accept && in_last) w_next = W_DRAIN;
      end
      W_DRAIN: if (drain_cnt) w_next = W_SWAP;
      W_SWAP:  if (swap_go) w_next = W_FILL;
      default: w_next = W_INIT;
    endcase
  end

  // init sweep address, drain timer and fill-bank pointer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      init_addr <= '0;
      drain_cnt <= 1'b0;
      fill_bank <= 1'b0;
    end else begin
      if (w_state == W_INIT) init_addr <= init_addr + 1'b1;
      drain_cnt <= (w_state == W_DRAIN) ? ~drain_cnt : 1'b0;
      if (swap_go) fill_bank <= ~fill_bank;
    end
  end

  // accumulate pipeline control
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld <= 1'b0;
      s1_idx <= '0;
      s1_dat <= '0;
      s2_vld <= 1'b0;
      s2_idx <= '0;
      s2_sum <= '0;
    end else begin
      s1_vld <= accept;
      if (accept) begin
        s1_idx <= in_index;
        s1_dat <= in_data;
      end
      s2_vld <= s1_vld;
      s2_idx <= s1_idx;
      s2_sum <= s1_sum;
    end
  end

  // synchronous read of the fill bank for the incoming pair
  always_ff @(posedge clk) begin
    s1_rd <= fill_bank ? bank1[in_index] : bank0[in_index];
  end

  // the read in s1 missed the write landing on the same edge; take that sum instead
  always_comb begin
    s1_base = (s2_vld && (s2_idx == s1_idx)) ? s2_sum : s1_rd;
    s1_sum  = {lane_add(s1_base[DATA_W-1:LANE_W], s1_dat[DATA_W-1:LANE_W]),
               lane_add(s1_base[LANE_W-1:0],      s1_dat[LANE_W-1:0])};
  end

  // steer writes: init zeroes both banks, otherwise fill bank accumulates and drain bank clears
  always_comb begin
    b0_we   = 1'b0;
    b0_addr = '0;
    b0_dat  = '0;
    b1_we   = 1'b0;
    b1_addr = '0;
    b1_dat  = '0;
    if (w_state == W_INIT) begin
      b0_we   = 1'b1;
      b0_addr = init_addr;
      b1_we   = 1'b1;
      b1_addr = init_addr;
    end else begin
      if (s1_vld) begin
        if (fill_bank) begin
          b1_we   = 1'b1;
          b1_addr = s1_idx;
          b1_dat  = s1_sum;
        end else begin
          b0_we   = 1'b1;
          b0_addr = s1_idx;
          b0_dat  = s1_sum;
        end
      end
      if (out_hs) begin
        if (fill_bank) begin
          b0_we   = 1'b1;
          b0_addr = out_index;
        end else begin
          b1_we   = 1'b1;
          b1_addr = out_index;
        end
      end
    end
  end

  // bank 0 storage
  always_ff @(posedge clk) begin
    if (b0_we) bank0[b0_addr] <= b0_dat;
  end

  // bank 1 storage
  always_ff @(posedge clk) begin
    if (b1_we) bank1[b1_addr] <= b1_dat;
  end

  // read-side state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= R_IDLE;
    else        r_state <= r_next;
  end

  // read-side next state; a swap on the final beat restarts streaming immediately
  always_comb begin
    r_next = r_state;
    case (r_state)
      R_IDLE:   if (swap_go) r_next = R_STREAM;
      R_STREAM: if (out_hs && out_last) r_next = swap_go ? R_STREAM : R_IDLE;
      default:  r_next = R_IDLE;
    endcase
  end

  // drain address and output register loaded straight from the drain bank
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_addr   <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_index <= '0;
      out_last  <= 1'b0;
    end else begin
      if (swap_go)      rd_addr <= '0;
      else if (rd_load) rd_addr <= rd_addr + 1'b1;
      if (rd_load) begin
        out_valid <= 1'b1;
        out_data  <= fill_bank ? bank0[rd_addr[IDX_W-1:0]] : bank1[rd_addr[IDX_W-1:0]];
        out_index <= rd_addr[IDX_W-1:0];
        out_last  <= (rd_addr[IDX_W-1:0] == IDX_W'(NUM_BINS - 1));
      end else if (out_hs) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pitch_shift_rebin.sv
// Bench for pitch_shift_rebin: directed and random frames against a per-frame bin array model.
// Expected spectra are built by summing accepted pairs per bin with integer lane arithmetic.
// Covers init timing, identity, collisions, lane overflow, output stalls, mid-stream reset.
module tb_pitch_shift_rebin;

  localparam int NB  = 2048;
  localparam int TMO = 12000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, in_last;
  logic [10:0] in_index;
  logic [43:0] in_data;
  logic        out_valid, out_ready, out_last;
  logic [43:0] out_data;
  logic [10:0] out_index;

  int n_checks = 0;
  int n_fail   = 0;

  logic [43:0] acc [NB];
  logic [43:0] exp_q [$];
  int          exp_bin = 0;

  pitch_shift_rebin dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_index (in_index),
    .in_data  (in_data),
    .in_last  (in_last),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_index(out_index),
    .out_last (out_last)
  );

  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // signed lane sum in plain integers, then wrap or clamp to 22 bits
  function automatic logic [21:0] model_lane(input logic [21:0] a, input logic [21:0] b);
    int sa, sb, s;
    sa = $signed(a);
    sb = $signed(b);
    s  = sa + sb;
`ifdef ACCUM_SAT_EN
    if (s > 2097151)  s = 2097151;
    if (s < -2097152) s = -2097152;
`endif
    return s[21:0];
  endfunction

  task automatic clear_model();
    for (int b = 0; b < NB; b++) acc[b] = '0;
    exp_q.delete();
    exp_bin = 0;
  endtask

  // called at a negedge; returns at the negedge after the pair was taken
  task automatic send_pair(input logic [10:0] idx, input logic [43:0] dat, input bit last);
    int g;
    g = 0;
    in_valid = 1'b1;
    in_index = idx;
    in_data  = dat;
    in_last  = last;
    while (in_ready !== 1'b1 && g < TMO) begin
      @(negedge clk);
      g++;
    end
    check("in_ready_wait", 64'(g < TMO), 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    acc[idx] = {model_lane(acc[idx][43:22], dat[43:22]), model_lane(acc[idx][21:0], dat[21:0])};
    if (last) begin
      for (int b = 0; b < NB; b++) begin
        exp_q.push_back(acc[b]);
        acc[b] = '0;
      end
    end
  endtask

  task automatic send_random(input int n, input int max_idx, input int gap_pct);
    logic [43:0] d;
    for (int k = 0; k < n; k++) begin
      d = {12'($urandom), 32'($urandom)};
      send_pair(11'($urandom_range(0, max_idx)), d, k == n - 1);
      if ($urandom_range(0, 99) < gap_pct) @(negedge clk);
    end
  endtask

  // mode 0: ready high, 1: toggling, 2: random
  task automatic consume(input int nbeats, input int mode);
    int got, cyc;
    logic pv, pr;
    logic [43:0] pd;
    logic [10:0] pi;
    logic [43:0] e;
    got = 0;
    cyc = 0;
    pv  = 1'b0;
    pr  = 1'b0;
    pd  = '0;
    pi  = '0;
    while (got < nbeats && cyc < TMO) begin
      @(negedge clk);
      cyc++;
      if (pv && !pr) begin
        check("stall_valid", 64'(out_valid), 64'd1);
        check("stall_data", 64'(out_data), 64'(pd));
        check("stall_index", 64'(out_index), 64'(pi));
      end
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = cyc[0];
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      if (out_valid && out_ready) begin
        e = '0;
        if (exp_q.size() == 0) check("exp_queue_empty", 64'd1, 64'd0);
        else e = exp_q.pop_front();
        check("bin_data", 64'(out_data), 64'(e));
        check("bin_index", 64'(out_index), 64'(exp_bin));
        check("bin_last", 64'(out_last), 64'(exp_bin == NB - 1));
        exp_bin = (exp_bin + 1) % NB;
        got++;
      end
      pv = out_valid;
      pr = out_ready;
      pd = out_data;
      pi = out_index;
    end
    check("consume_timeout", 64'(got), 64'(nbeats));
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic wait_ready();
    int g;
    g = 0;
    while (in_ready !== 1'b1 && g < TMO) begin
      @(negedge clk);
      g++;
    end
    check("init_done_wait", 64'(g < TMO), 64'd1);
  endtask

  initial begin
    // reset with stray input traffic that must be ignored
    rst_n     = 1'b0;
    in_valid  = 1'b1;
    in_index  = 11'd3;
    in_data   = 44'h1;
    in_last   = 1'b1;
    out_ready = 1'b0;
    clear_model();
    repeat (3) @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data", 64'(out_data), 64'd0);
    check("rst_out_index", 64'(out_index), 64'd0);
    check("rst_out_last", 64'(out_last), 64'd0);
    rst_n = 1'b1;
    for (int c = 1; c <= NB + 5; c++) begin
      @(negedge clk);
      if (c == 1) check("init_ready_c1", 64'(in_ready), 64'd0);
      if (c == NB - 1) begin
        check("init_ready_before", 64'(in_ready), 64'd0);
        in_valid = 1'b0;
        in_last  = 1'b0;
      end
      if (c == NB) check("init_ready_after", 64'(in_ready), 64'd1);
      if (c == NB + 5) begin
        out_ready = 1'b1;
        check("init_out_valid", 64'(out_valid), 64'd0);
        check("init_out_data", 64'(out_data), 64'd0);
      end
    end
    out_ready = 1'b0;

    // identity frame: bin i = {i, -i}
    fork
      for (int i = 0; i < NB; i++) send_pair(11'(i), {22'(i), 22'(-i)}, i == NB - 1);
      consume(NB, 0);
    join

    // collision: three back-to-back hits on bin 5
    for (int k = 0; k < 3; k++) send_pair(11'd5, {22'h7FFF, 22'h0}, k == 2);
    check("collision_model_bin5", 64'(exp_q[5]), 64'({22'h17FFD, 22'h0}));
    consume(NB, 0);

    // lane overflow on bin 0
    send_pair(11'd0, {22'h1FFFFF, 22'h0}, 1'b0);
    send_pair(11'd0, {22'h1FFFFF, 22'h0}, 1'b1);
    consume(NB, 0);

    // back-to-back frames with output backpressure, dense collisions
    fork
      begin
        send_random(500, NB - 1, 20);
        send_random(300, 7, 0);
        send_random(5, 3, 0);
      end
      begin
        consume(NB, 1);
        consume(NB, 1);
        consume(NB, 2);
      end
    join

    // reset in the middle of streaming
    fork
      send_random(400, NB - 1, 10);
      consume(700, 0);
    join
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_out_data", 64'(out_data), 64'd0);
    check("midrst_out_index", 64'(out_index), 64'd0);
    check("midrst_out_last", 64'(out_last), 64'd0);
    check("midrst_in_ready", 64'(in_ready), 64'd0);
    clear_model();
    @(negedge clk);
    rst_n = 1'b1;
    wait_ready();
    send_pair(11'd7, {22'h12345, 22'h3FFFFF}, 1'b1);
    consume(NB, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
